// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed N-digit BCD to 7-segment display driver.
// Synchronises the BCD nibbles, snapshots them once per scan frame and
// time-multiplexes the digits onto one shared segment bus with a one-hot
// digit enable.
// Optional build macro SEG_LZ_BLANK_EN: blank leading zeros of the snapshot.
// Digit 0 is always shown.
module seg_scan_driver #(
    parameter int N_DIGITS       = 4,
    parameter int SYNC_STAGES    = 3,
    parameter int SCAN_DIV       = 50000,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*N_DIGITS-1:0] digits_in,
    output logic [6:0]            seg,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_tick
);

    localparam int         CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int         IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int         DW      = 4 * N_DIGITS;
    localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

    logic [DW-1:0]       sync_q [SYNC_STAGES];
    logic [DW-1:0]       sync_d [SYNC_STAGES];
    logic [DW-1:0]       snap_q, snap_d;
    logic [CNT_W-1:0]    scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                started_q, started_d;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                frame_tick_q, frame_tick_d;

    logic                terminal;
    logic                last_digit;
    logic                load_snap;
    logic                blank;
    logic [3:0]          cur_nib;
    logic [6:0]          seg_raw;
`ifdef SEG_LZ_BLANK_EN
    logic                zero_run;
`endif

    // BCD to segments {a,b,c,d,e,f,g}, 1 = lit; codes A..F are blank.
    function automatic logic [6:0] bcd_decode(input logic [3:0] d);
        case (d)
            4'd0:    bcd_decode = 7'h7E;
            4'd1:    bcd_decode = 7'h30;
            4'd2:    bcd_decode = 7'h6D;
            4'd3:    bcd_decode = 7'h79;
            4'd4:    bcd_decode = 7'h33;
            4'd5:    bcd_decode = 7'h5B;
            4'd6:    bcd_decode = 7'h5F;
            4'd7:    bcd_decode = 7'h70;
            4'd8:    bcd_decode = 7'h7F;
            4'd9:    bcd_decode = 7'h7B;
            default: bcd_decode = 7'h00;
        endcase
    endfunction

    // Synchroniser chain: plain shift, nothing is decoded before the last stage.
    always_comb begin
        sync_d[0] = digits_in;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    // Scan timing and frame snapshot: the snapshot only changes at a frame
    // boundary (or the first edge after reset) so a frame is always coherent.
    always_comb begin
        terminal   = (scan_cnt_q == CNT_W'(SCAN_DIV - 1));
        last_digit = (idx_q == IDX_W'(N_DIGITS - 1));
        scan_cnt_d = terminal ? '0 : scan_cnt_q + CNT_W'(1);
        // NOTE: every signal of an always_comb gets a value on every path
        // (defaults first), otherwise synthesis infers a latch.
        idx_d      = idx_q;
        if (terminal) begin
            idx_d = last_digit ? '0 : idx_q + IDX_W'(1);
        end
        load_snap    = !started_q || (terminal && last_digit);
        snap_d       = load_snap ? sync_q[SYNC_STAGES-1] : snap_q;
        started_d    = 1'b1;
        frame_tick_d = load_snap;
    end

    // Output stage: select the current digit, decode it and apply blanking/polarity.
    always_comb begin
        cur_nib = 4'd0;
        an_d    = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib = snap_q[4*i +: 4];
                an_d[i] = 1'b1;
            end
        end
`ifdef SEG_LZ_BLANK_EN
        // Walk down from the top digit; a digit is blank while everything
        // from it upwards is zero.
        zero_run = 1'b1;
        blank    = 1'b0;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run && (snap_q[4*i +: 4] == 4'd0);
            if (idx_q == IDX_W'(i)) begin
                blank = zero_run;
            end
        end
`else
        blank = 1'b0;
`endif
        seg_raw = blank ? 7'h00 : bcd_decode(cur_nib);
        seg_d   = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
    end

    // State and output registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the synchroniser array is ordinary flops, not a RAM, so it
            // is reset element by element like the rest of the state.
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            snap_q       <= '0;
            scan_cnt_q   <= '0;
            idx_q        <= '0;
            started_q    <= 1'b0;
            an_q         <= '0;
            seg_q        <= SEG_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of its neighbours, independent of statement order.
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            snap_q       <= snap_d;
            scan_cnt_q   <= scan_cnt_d;
            idx_q        <= idx_d;
            started_q    <= started_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: randomized scoreboard bench for seg_scan_driver
// (N_DIGITS=4, SCAN_DIV=4, SYNC_STAGES=3, active-high segments).
module tb_seg_scan_driver;

    localparam int N  = 4;
    localparam int SD = 4;
    localparam int SS = 3;
    localparam int FL = N * SD;   // clk edges per frame

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] digits_in = 16'h0000;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_tick;

    typedef struct packed {
        logic       ft;
        logic [3:0] an;
        logic [6:0] seg;
    } obs_t;

    obs_t        exp_q[$];
    int          exp_edge_q[$];
    logic [15:0] din_hist[$];     // din_hist[k-1] = digits_in seen at edge k
    int          edge_n = 0;      // edges since the last reset release
    bit          running = 1'b0;
    int          checks = 0;
    int          errors = 0;

    seg_scan_driver #(
        .N_DIGITS       (N),
        .SYNC_STAGES    (SS),
        .SCAN_DIV       (SD),
        .SEG_ACTIVE_LOW (0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits_in  (digits_in),
        .seg        (seg),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected segments for digit d of a snapshot, straight from the decode table.
    function automatic logic [6:0] exp_seg(input logic [15:0] snap, input int d);
        logic [3:0] nib;
        nib = 4'((snap >> (4 * d)) & 16'hF);
`ifdef SEG_LZ_BLANK_EN
        if (d > 0 && (snap >> (4 * d)) == 16'h0) return 7'h00;
`endif
        case (nib)
            4'd0: return 7'h7E;
            4'd1: return 7'h30;
            4'd2: return 7'h6D;
            4'd3: return 7'h79;
            4'd4: return 7'h33;
            4'd5: return 7'h5B;
            4'd6: return 7'h5F;
            4'd7: return 7'h70;
            4'd8: return 7'h7F;
            4'd9: return 7'h7B;
            default: return 7'h00;
        endcase
    endfunction

    // Outputs right after edge e: they show the digit selected before edge e
    // from the snapshot loaded at the latest load edge before e. Loads happen
    // at edge 1 and at every multiple of FL; a load captures the input seen
    // SS edges earlier (zero if that lies before the reset release).
    function automatic obs_t model(input int e);
        obs_t        o;
        int          idx;
        int          l;
        logic [15:0] snap;
        idx = ((e - 1) / SD) % N;
        if (e == 1) begin
            snap = 16'h0;
        end else begin
            l    = (e - 1 >= FL) ? ((e - 1) / FL) * FL : 1;
            snap = (l - SS >= 1) ? din_hist[l - SS - 1] : 16'h0;
        end
        o.ft  = (e == 1) || (e % FL == 0);
        o.an  = 4'(1 << idx);
        o.seg = exp_seg(snap, idx);
        return o;
    endfunction

    // Stimulus side of the scoreboard: record input and push the expectation.
    initial forever begin
        @(posedge clk);
        if (running) begin
            edge_n++;
            din_hist.push_back(digits_in);
            exp_q.push_back(model(edge_n));
            exp_edge_q.push_back(edge_n);
        end
    end

    // Monitor: pop one expectation per presented output cycle and compare.
    initial forever begin
        @(negedge clk);
        if (running) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow: got empty queue expected an entry");
            end else begin
                obs_t want;
                int   en;
                want = exp_q.pop_front();
                en   = exp_edge_q.pop_front();
                check($sformatf("edge%0d {ft,an,seg}", en),
                      {20'd0, frame_tick, an, seg}, {20'd0, want});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic release_reset();
        @(negedge clk);
        #2;
        rst_n   = 1'b1;
        running = 1'b1;
    endtask

    task automatic wait_idx(input int target);
        int n;
        n = 0;
        while (((edge_n / SD) % N) != target && n < 64) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("wait_idx%0d_timeout", target), 32'(n >= 64), 32'd0);
    endtask

    task automatic run_pattern(input logic [15:0] v, input int cycles);
        @(negedge clk);
        #1;
        digits_in = v;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        // Reset hold with changing inputs: outputs stay at reset values.
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #($urandom_range(1, 4));
            digits_in = 16'($urandom);
            check("rst_an", 32'(an), 32'h0);
            check("rst_seg", 32'(seg), 32'h00);
            check("rst_ft", 32'(frame_tick), 32'h0);
        end

        // Static scan of 1234 over several frames.
        digits_in = 16'h1234;
        release_reset();
        repeat (3 * FL) @(negedge clk);

        // Coherence: input changes mid-frame while digit 1 is being shown.
        wait_idx(1);
        digits_in = 16'h5678;
        repeat (3 * FL) @(negedge clk);

        // Invalid BCD nibbles blank their digit.
        run_pattern(16'h00A9, 3 * FL);

        // Asynchronous reset between edges while digit 2 is selected.
        wait_idx(2);
        #1;
        rst_n   = 1'b0;
        running = 1'b0;
        exp_q.delete();
        exp_edge_q.delete();
        din_hist.delete();
        edge_n = 0;
        #1;
        check("midrst_an", 32'(an), 32'h0);
        check("midrst_seg", 32'(seg), 32'h00);
        check("midrst_ft", 32'(frame_tick), 32'h0);
        repeat (2) @(negedge clk);
        check("midrst_hold_an", 32'(an), 32'h0);
        release_reset();
        @(negedge clk);
        #1;
        check("restart_an", 32'(an), 32'h1);
        repeat (2 * FL) @(negedge clk);

        // Leading-zero patterns (blanked only when the option is built in).
        run_pattern(16'h0007, 3 * FL);
        run_pattern(16'h0000, 3 * FL);
        run_pattern(16'h0107, 3 * FL);

        // Randomized values held for random spans, mostly valid BCD.
        for (int t = 0; t < 40; t++) begin
            logic [15:0] v;
            for (int k = 0; k < 4; k++) begin
                v[4*k +: 4] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                          : 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 1) == 1) v = v >> (4 * $urandom_range(1, 3));
            run_pattern(v, $urandom_range(1, 40));
        end

        @(negedge clk);
        #1;
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
